// File: rtl/usb_tx_data_pkg.sv
// Shared definitions for the USB data-packet transmitter.
// PID codes, FSM state encoding and the reflected CRC16 byte update.
package usb_tx_data_pkg;

    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_DATA2 = 4'b0111;
    localparam logic [3:0] PID_MDATA = 4'b1111;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;
    localparam logic [3:0] PID_NYET  = 4'b0110;

    localparam logic [15:0] CRC16_INIT = 16'hFFFF;
    localparam logic [15:0] CRC16_POLY = 16'hA001;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PID,
        ST_DATA,
        ST_CRC_LO,
        ST_CRC_HI,
        ST_DRAIN
    } state_t;

    // LSB-first CRC: 0x8005 bit-reversed is 0xA001
    function automatic logic [15:0] crc16_byte(
        input logic [15:0] crc,
        input logic [7:0]  data
    );
        logic [15:0] c;
        c = crc ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC16_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/usb_tx_data_crc16.sv
// Byte-wide USB CRC16 accumulator.
// Output is the complemented register, ready to transmit.
module usb_crc16
    import usb_tx_data_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [15:0] crc
);

    logic [15:0] crc_q;

    always_ff @(posedge clk) begin
        if (rst || init) begin
            crc_q <= CRC16_INIT;
        end else if (en) begin
            crc_q <= crc16_byte(crc_q, data);
        end
    end

    assign crc = ~crc_q;

endmodule

// File: rtl/usb_tx_data.sv
// USB data-packet framer: PID, payload passthrough, CRC16, overflow drain.
// Define USB_TX_TOGGLE_EN for per-endpoint DATA0/DATA1 toggle tracking.
module usb_tx_data
    import usb_tx_data_pkg::*;
#(
    parameter int MAX_PACKET = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data_tdata,
    input  logic       tx_data_tlast,
    input  logic       tx_data_tvalid,
    output logic       tx_data_tready,
    input  logic       tx_data_zlp,
    input  logic [1:0] tx_data_type,
    input  logic [3:0] tx_endpoint,
    input  logic       rx_ack,
    input  logic       tx_toggle_clr,
    output logic [7:0] tx_tdata,
    output logic       tx_tlast,
    output logic       tx_tvalid,
    input  logic       tx_tready,
    output logic       busy
);

    localparam logic [10:0] MAX_CNT = 11'(MAX_PACKET);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  pid_q;
    logic        zlp_q;
    logic        drain_q;
    logic [10:0] cnt;
    logic [1:0]  type_sel;
    logic [15:0] crc;
    logic        start;
    logic        in_strobe;
    logic        at_max;
    logic        unused_cfg;

    assign start     = (state == ST_IDLE) && (tx_data_tvalid || tx_data_zlp);
    assign in_strobe = (state == ST_DATA) && tx_data_tvalid && tx_tready;
    assign at_max    = (cnt + 11'd1) == MAX_CNT;
    assign busy      = (state != ST_IDLE);

`ifdef USB_TX_TOGGLE_EN
    logic [15:0] toggle;
    logic [3:0]  ep_q;
    logic [3:0]  last_ep;

    always_ff @(posedge clk) begin
        if (rst) begin
            toggle  <= '0;
            ep_q    <= '0;
            last_ep <= '0;
        end else begin
            if (start) ep_q <= tx_endpoint;
            if (state == ST_CRC_HI && tx_tready) last_ep <= ep_q;
            if (rx_ack) toggle[last_ep] <= ~toggle[last_ep];
            // later assignment makes clear win over ack
            if (tx_toggle_clr) toggle[tx_endpoint] <= 1'b0;
        end
    end

    assign type_sel   = toggle[tx_endpoint] ? 2'b10 : 2'b00;
    assign unused_cfg = ^tx_data_type;
`else
    assign type_sel   = tx_data_type;
    assign unused_cfg = ^{rx_ack, tx_toggle_clr, tx_endpoint};
`endif

    usb_crc16 u_crc (
        .clk  (clk),
        .rst  (rst),
        .init (state == ST_PID),
        .en   (in_strobe),
        .data (tx_data_tdata),
        .crc  (crc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            pid_q   <= '0;
            zlp_q   <= 1'b0;
            drain_q <= 1'b0;
            cnt     <= '0;
        end else begin
            state <= state_nxt;
            if (start) begin
                pid_q   <= {type_sel, 2'b11};
                zlp_q   <= ~tx_data_tvalid;
                drain_q <= 1'b0;
                cnt     <= '0;
            end
            if (in_strobe) begin
                cnt <= cnt + 11'd1;
                if (at_max && !tx_data_tlast) drain_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        tx_tvalid      = 1'b0;
        tx_tdata       = 8'h00;
        tx_tlast       = 1'b0;
        tx_data_tready = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_PID;
            end
            ST_PID: begin
                tx_tvalid = 1'b1;
                tx_tdata  = {~pid_q, pid_q};
                if (tx_tready) state_nxt = zlp_q ? ST_CRC_LO : ST_DATA;
            end
            ST_DATA: begin
                tx_tvalid      = tx_data_tvalid;
                tx_tdata       = tx_data_tdata;
                tx_data_tready = tx_tready;
                if (in_strobe && (tx_data_tlast || at_max)) begin
                    state_nxt = ST_CRC_LO;
                end
            end
            ST_CRC_LO: begin
                tx_tvalid = 1'b1;
                tx_tdata  = crc[7:0];
                if (tx_tready) state_nxt = ST_CRC_HI;
            end
            ST_CRC_HI: begin
                tx_tvalid = 1'b1;
                tx_tlast  = 1'b1;
                tx_tdata  = crc[15:8];
                if (tx_tready) state_nxt = drain_q ? ST_DRAIN : ST_IDLE;
            end
            ST_DRAIN: begin
                tx_data_tready = 1'b1;
                if (tx_data_tvalid && tx_data_tlast) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_usb_tx_data.sv
// Directed bench for usb_tx_data with MAX_PACKET=8.
// Covers both builds (USB_TX_TOGGLE_EN defined or not).
module tb_usb_tx_data;

    localparam int MAXP = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data_tdata;
    logic       tx_data_tlast;
    logic       tx_data_tvalid;
    logic       tx_data_tready;
    logic       tx_data_zlp;
    logic [1:0] tx_data_type;
    logic [3:0] tx_endpoint;
    logic       rx_ack;
    logic       tx_toggle_clr;
    logic [7:0] tx_tdata;
    logic       tx_tlast;
    logic       tx_tvalid;
    logic       tx_tready;
    logic       busy;

    int passed = 0;
    int total  = 0;
    int acc;
    logic [7:0] out_d[$];
    logic       out_l[$];

    always #5 clk = ~clk;

    usb_tx_data #(.MAX_PACKET(MAXP)) dut (
        .clk            (clk),
        .rst            (rst),
        .tx_data_tdata  (tx_data_tdata),
        .tx_data_tlast  (tx_data_tlast),
        .tx_data_tvalid (tx_data_tvalid),
        .tx_data_tready (tx_data_tready),
        .tx_data_zlp    (tx_data_zlp),
        .tx_data_type   (tx_data_type),
        .tx_endpoint    (tx_endpoint),
        .rx_ack         (rx_ack),
        .tx_toggle_clr  (tx_toggle_clr),
        .tx_tdata       (tx_tdata),
        .tx_tlast       (tx_tlast),
        .tx_tvalid      (tx_tvalid),
        .tx_tready      (tx_tready),
        .busy           (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // bit-serial reference of the USB CRC16 register
    function automatic logic [15:0] crc_bits(input logic [15:0] c,
                                             input logic [7:0] b);
        logic fb;
        for (int i = 0; i < 8; i++) begin
            fb = c[0] ^ b[i];
            c  = c >> 1;
            if (fb) c = c ^ 16'hA001;
        end
        return c;
    endfunction

    task automatic idle_inputs();
        tx_data_tvalid = 1'b0;
        tx_data_tdata  = 8'h00;
        tx_data_tlast  = 1'b0;
        tx_data_zlp    = 1'b0;
        rx_ack         = 1'b0;
        tx_toggle_clr  = 1'b0;
        tx_tready      = 1'b1;
    endtask

    task automatic send(input string tag, input int n,
                        input logic [7:0] base, input logic [1:0] typ,
                        input logic [3:0] ep, input bit zlp, input bit rnd);
        int   cyc;
        bit   seen;
        bit   stall;
        logic [7:0] pd;
        acc = 0; cyc = 0; seen = 0; stall = 0; pd = 8'h00;
        out_d.delete();
        out_l.delete();
        while (!(acc >= n && seen) && cyc < 300) begin
            @(negedge clk);
            tx_data_tvalid = (acc < n);
            tx_data_tdata  = 8'(base + acc);
            tx_data_tlast  = (acc == n - 1);
            tx_data_zlp    = zlp && (cyc == 0);
            tx_data_type   = typ;
            tx_endpoint    = ep;
            tx_tready      = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (stall) begin
                chk({tag, "_hold_v"}, tx_tvalid, 1'b1);
                chk({tag, "_hold_d"}, tx_tdata, pd);
            end
            if (seen) chk({tag, "_drain_v"}, tx_tvalid, 1'b0);
            if (out_d.size() == 0)
                chk({tag, "_rdy_pre"}, tx_data_tready, 1'b0);
            if (tx_tvalid && tx_tready) begin
                out_d.push_back(tx_tdata);
                out_l.push_back(tx_tlast);
                if (tx_tlast) seen = 1;
            end
            if (tx_data_tvalid && tx_data_tready) acc++;
            stall = tx_tvalid && !tx_tready;
            pd    = tx_tdata;
            cyc++;
        end
        chk({tag, "_done"}, 32'(acc >= n && seen), 1);
        chk({tag, "_acc"}, acc, n);
        @(negedge clk);
        idle_inputs();
        #1;
        chk({tag, "_busy_end"}, busy, 1'b0);
        chk({tag, "_tv_end"}, tx_tvalid, 1'b0);
        chk({tag, "_rdy_end"}, tx_data_tready, 1'b0);
    endtask

    task automatic check_pkt(input string tag, input logic [7:0] pid,
                             input int n, input logic [7:0] base);
        logic [7:0]  exp_q[$];
        logic [15:0] c;
        int m;
        int k;
        m = (n > MAXP) ? MAXP : n;
        c = 16'hFFFF;
        exp_q.push_back(pid);
        for (int i = 0; i < m; i++) begin
            exp_q.push_back(8'(base + i));
            c = crc_bits(c, 8'(base + i));
        end
        c = ~c;
        exp_q.push_back(c[7:0]);
        exp_q.push_back(c[15:8]);
        chk({tag, "_len"}, out_d.size(), exp_q.size());
        k = (out_d.size() < exp_q.size()) ? out_d.size() : exp_q.size();
        for (int i = 0; i < k; i++) begin
            chk($sformatf("%s_b%0d", tag, i), out_d[i], exp_q[i]);
            chk($sformatf("%s_l%0d", tag, i), out_l[i],
                32'(i == exp_q.size() - 1));
        end
    endtask

    task automatic pulse(input logic a, input logic c, input logic [3:0] ep);
        @(negedge clk);
        rx_ack        = a;
        tx_toggle_clr = c;
        tx_endpoint   = ep;
        @(negedge clk);
        rx_ack        = 1'b0;
        tx_toggle_clr = 1'b0;
    endtask

`ifdef USB_TX_TOGGLE_EN
    localparam logic [7:0] PID_T10 = 8'hC3;
    localparam logic [7:0] PID_T01 = 8'hC3;
`else
    localparam logic [7:0] PID_T10 = 8'h4B;
    localparam logic [7:0] PID_T01 = 8'h87;
`endif

    initial begin
        rst           = 1'b1;
        tx_data_type  = 2'b00;
        tx_endpoint   = 4'd0;
        idle_inputs();
        repeat (3) @(negedge clk);
        #1;
        chk("rst_tvalid", tx_tvalid, 1'b0);
        chk("rst_tlast", tx_tlast, 1'b0);
        chk("rst_rdy", tx_data_tready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        send("zlp", 0, 8'h00, 2'b00, 4'd0, 1'b1, 1'b0);
        check_pkt("zlp", 8'hC3, 0, 8'h00);

        send("p4", 4, 8'h00, 2'b10, 4'd0, 1'b0, 1'b0);
        check_pkt("p4", PID_T10, 4, 8'h00);

        send("rnd", 6, 8'h40, 2'b01, 4'd0, 1'b0, 1'b1);
        check_pkt("rnd", PID_T01, 6, 8'h40);

        send("max8", 8, 8'h20, 2'b00, 4'd0, 1'b0, 1'b0);
        check_pkt("max8", 8'hC3, 8, 8'h20);

        send("ovf", 10, 8'h10, 2'b00, 4'd0, 1'b0, 1'b0);
        check_pkt("ovf", 8'hC3, 10, 8'h10);

        @(negedge clk);
        tx_data_tvalid = 1'b1;
        tx_data_tdata  = 8'hAA;
        tx_data_tlast  = 1'b0;
        tx_data_type   = 2'b00;
        @(negedge clk);
        #1;
        chk("rstmid_pid", tx_tdata, 8'hC3);
        @(negedge clk);
        #1;
        chk("rstmid_data_rdy", tx_data_tready, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        #1;
        chk("rstmid_tvalid", tx_tvalid, 1'b0);
        chk("rstmid_busy", busy, 1'b0);
        send("rz", 0, 8'h00, 2'b00, 4'd0, 1'b1, 1'b0);
        check_pkt("rz", 8'hC3, 0, 8'h00);

`ifdef USB_TX_TOGGLE_EN
        send("t1", 0, 8'h00, 2'b10, 4'd3, 1'b1, 1'b0);
        check_pkt("t1", 8'hC3, 0, 8'h00);
        pulse(1'b1, 1'b0, 4'd3);
        send("t2", 0, 8'h00, 2'b00, 4'd3, 1'b1, 1'b0);
        check_pkt("t2", 8'h4B, 0, 8'h00);
        pulse(1'b0, 1'b1, 4'd3);
        send("t3", 0, 8'h00, 2'b10, 4'd3, 1'b1, 1'b0);
        check_pkt("t3", 8'hC3, 0, 8'h00);
        pulse(1'b1, 1'b1, 4'd3);
        send("t4", 0, 8'h00, 2'b10, 4'd3, 1'b1, 1'b0);
        check_pkt("t4", 8'hC3, 0, 8'h00);
`else
        pulse(1'b1, 1'b0, 4'd0);
        send("n1", 0, 8'h00, 2'b00, 4'd0, 1'b1, 1'b0);
        check_pkt("n1", 8'hC3, 0, 8'h00);
        pulse(1'b1, 1'b1, 4'd0);
        send("n2", 0, 8'h00, 2'b11, 4'd0, 1'b1, 1'b0);
        check_pkt("n2", 8'h0F, 0, 8'h00);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
